fc_result_packer: RTL and testbench

- Sits between the fully-connected MAC stage and the core write master.
- Accepts one 32-bit signed MAC result per Valid_i and requantizes it to a signed 8-bit value (round, optional ReLU, saturate).
- Packs 64 bytes into a 512-bit line and holds completed lines in a 2-entry line FIFO.
- Presents lines to the write master on a Req/Ack handshake and back-pressures the MAC with Halt_o.

---
 rtl/fc_result_packer.sv | 204 ++++++++++++++++++++
 tb/tb_fc_result_packer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_result_packer.sv
// fc_result_packer: requantizes 32-bit MAC results to int8 and packs 64 lanes per 512-bit write line.
// Latency: a line is committed on the edge that accepts its last byte; WriteReq_o is visible the cycle after.
// Backpressure: Halt_o rises when both FIFO entries hold lines; a Valid_i during Halt_o is dropped and Overflow_o latches.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   Start_i                  synchronous job clear; wins over same-cycle Valid_i / WriteAck_i
//   ShiftBp_i, Relu_i        requantization controls (rounding right shift, optional ReLU)
//   Valid_i, Data_i, Last_i  incoming MAC result stream
//   Halt_o                   upstream must hold off while set
//   WriteData_o/ByteEnable_o head line of the FIFO and its lane mask
//   WriteReq_o, WriteAck_i   write-master handshake; an ack pops the head
//   Done_o                   one-cycle pulse after the job's final line is acked
//   Count_o                  lines acked since Start_i
//   Overflow_o               sticky protocol-violation flag

// Small generic FIFO with synchronous clear; head is read combinationally.
// Latency: a pushed entry is visible at headDat the cycle after the push.
// Backpressure: none internally; the owner must not push when count == DEPTH.
module fc_line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       pushVld,
  input  logic [WIDTH-1:0]           pushDat,
  input  logic                       popVld,
  output logic [WIDTH-1:0]           headDat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign headDat = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushVld) begin
        mem[wrPtr] <= pushDat;
        wrPtr      <= nextPtr(wrPtr);
      end
      if (popVld) rdPtr <= nextPtr(rdPtr);
      case ({pushVld, popVld})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module fc_result_packer #(
  parameter int AvalonData_WIDTH       = 512,
  parameter int AvalonByteEnable_WIDTH = 64,
  parameter int FIFO_DEPTH             = 2,
  parameter int COUNT_WIDTH            = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              Start_i,
  input  logic [4:0]                        ShiftBp_i,
  input  logic                              Relu_i,
  input  logic                              Valid_i,
  input  logic [31:0]                       Data_i,
  input  logic                              Last_i,
  output logic                              Halt_o,
  output logic [AvalonData_WIDTH-1:0]       WriteData_o,
  output logic [AvalonByteEnable_WIDTH-1:0] WriteByteEnable_o,
  output logic                              WriteReq_o,
  input  logic                              WriteAck_i,
  output logic                              Done_o,
  output logic [COUNT_WIDTH-1:0]            Count_o,
  output logic                              Overflow_o
);
  localparam int LANE_W  = $clog2(AvalonByteEnable_WIDTH);
  localparam int FIFO_CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                              last;
    logic [AvalonByteEnable_WIDTH-1:0] mask;
    logic [AvalonData_WIDTH-1:0]       data;
  } lineEntry_t;

  // ---------------- requantization ----------------
  // 33-bit working width: the rounding add on a near-max positive input cannot wrap.
  logic signed [32:0] roundSum;
  logic signed [32:0] rounded;
  logic [7:0]         qByte;

  always_comb begin
    roundSum = {Data_i[31], Data_i};
    if (ShiftBp_i != 5'd0) roundSum = roundSum + (33'sd1 <<< (ShiftBp_i - 5'd1));
    rounded = roundSum >>> ShiftBp_i;
    if (Relu_i && rounded[32]) rounded = '0;
    if (rounded > 33'sd127)       qByte = 8'h7F;
    else if (rounded < -33'sd128) qByte = 8'h80;
    else                          qByte = rounded[7:0];
  end

  // ---------------- packing ----------------
  logic [LANE_W-1:0]                 laneCnt;
  logic [AvalonData_WIDTH-1:0]       lineReg;
  logic [AvalonByteEnable_WIDTH-1:0] maskReg;
  logic [AvalonData_WIDTH-1:0]       mergedLine;
  logic [AvalonByteEnable_WIDTH-1:0] mergedMask;
  logic [FIFO_CW-1:0]                fifoCount;
  lineEntry_t                        pushEntry;
  lineEntry_t                        headEntry;
  logic                              accept;
  logic                              commit;
  logic                              pop;

  assign WriteReq_o = (fifoCount != '0);
  assign Halt_o     = (fifoCount == FIFO_CW'(FIFO_DEPTH));

  // Start_i outranks both stream directions for the cycle it is high.
  assign accept = Valid_i & ~Halt_o & ~Start_i;
  assign commit = accept & ((laneCnt == LANE_W'(AvalonByteEnable_WIDTH - 1)) | Last_i);
  assign pop    = WriteAck_i & WriteReq_o & ~Start_i;

  // The committed line includes the byte arriving on the committing edge.
  always_comb begin
    mergedLine                       = lineReg;
    mergedLine[{laneCnt, 3'b000} +: 8] = qByte;
    mergedMask                       = maskReg;
    mergedMask[laneCnt]              = 1'b1;
    pushEntry.last                   = Last_i;
    pushEntry.mask                   = mergedMask;
    pushEntry.data                   = mergedLine;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      laneCnt <= '0;
      lineReg <= '0;
      maskReg <= '0;
    end else if (Start_i || commit) begin
      laneCnt <= '0;
      lineReg <= '0;
      maskReg <= '0;
    end else if (accept) begin
      laneCnt <= laneCnt + LANE_W'(1);
      lineReg <= mergedLine;
      maskReg <= mergedMask;
    end
  end

  // ---------------- line FIFO ----------------
  fc_line_fifo #(
    .WIDTH ($bits(lineEntry_t)),
    .DEPTH (FIFO_DEPTH)
  ) uLineFifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (Start_i),
    .pushVld (commit),
    .pushDat (pushEntry),
    .popVld  (pop),
    .headDat (headEntry),
    .count   (fifoCount)
  );

  assign WriteData_o       = headEntry.data;
  assign WriteByteEnable_o = headEntry.mask;

  // ---------------- status ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Done_o     <= 1'b0;
      Count_o    <= '0;
      Overflow_o <= 1'b0;
    end else begin
      Done_o <= pop & headEntry.last;
      if (Start_i) begin
        Count_o    <= '0;
        Overflow_o <= 1'b0;
      end else begin
        if (pop) Count_o <= Count_o + COUNT_WIDTH'(1);
        if (Valid_i && Halt_o) Overflow_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fc_result_packer.sv
// tb_fc_result_packer: scoreboard bench for fc_result_packer.
// Expected lines are built from the stimulus and queued at commit time, then popped on each ack.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_fc_result_packer;
  localparam int W  = 512;
  localparam int BE = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start_i;
  logic [4:0]    ShiftBp_i;
  logic          Relu_i;
  logic          Valid_i;
  logic [31:0]   Data_i;
  logic          Last_i;
  logic          Halt_o;
  logic [W-1:0]  WriteData_o;
  logic [BE-1:0] WriteByteEnable_o;
  logic          WriteReq_o;
  logic          WriteAck_i;
  logic          Done_o;
  logic [CW-1:0] Count_o;
  logic          Overflow_o;

  always #5 clk = ~clk;

  fc_result_packer dut (
    .clk               (clk),
    .rst               (rst),
    .Start_i           (Start_i),
    .ShiftBp_i         (ShiftBp_i),
    .Relu_i            (Relu_i),
    .Valid_i           (Valid_i),
    .Data_i            (Data_i),
    .Last_i            (Last_i),
    .Halt_o            (Halt_o),
    .WriteData_o       (WriteData_o),
    .WriteByteEnable_o (WriteByteEnable_o),
    .WriteReq_o        (WriteReq_o),
    .WriteAck_i        (WriteAck_i),
    .Done_o            (Done_o),
    .Count_o           (Count_o),
    .Overflow_o        (Overflow_o)
  );

  typedef struct packed {
    logic          last;
    logic [BE-1:0] mask;
    logic [W-1:0]  data;
  } ent_t;

  ent_t          expQ[$];
  logic [W-1:0]  mLine;
  logic [BE-1:0] mMask;
  int            mLane;
  logic [CW-1:0] expCount;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] refQuant(input logic [31:0] d, input int s, input bit relu);
    longint v;
    v = longint'($signed(d));
    if (s > 0) v = (v + (longint'(1) << (s - 1))) >>> s;
    if (relu && v < 0) v = 0;
    if (v > 127)  return 8'h7F;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  task automatic modelClear();
    mLine    = '0;
    mMask    = '0;
    mLane    = 0;
    expCount = '0;
    expQ.delete();
  endtask

  task automatic sendItem(input logic [31:0] d, input bit last);
    ent_t e;
    @(negedge clk);
    Valid_i    = 1'b1;
    Data_i     = d;
    Last_i     = last;
    WriteAck_i = 1'b0;
    mLine[mLane*8 +: 8] = refQuant(d, int'(ShiftBp_i), Relu_i);
    mMask[mLane]        = 1'b1;
    if (mLane == BE - 1 || last) begin
      e.last = last;
      e.mask = mMask;
      e.data = mLine;
      expQ.push_back(e);
      mLine = '0;
      mMask = '0;
      mLane = 0;
    end else begin
      mLane++;
    end
  endtask

  task automatic sendRamp(input int n, input int base, input bit lastAtEnd);
    for (int k = 0; k < n; k++) sendItem(32'(base + k), lastAtEnd && (k == n - 1));
  endtask

  task automatic idle();
    @(negedge clk);
    Valid_i    = 1'b0;
    Last_i     = 1'b0;
    WriteAck_i = 1'b0;
    Start_i    = 1'b0;
  endtask

  task automatic ackOne();
    ent_t e;
    @(negedge clk);
    Valid_i = 1'b0;
    Last_i  = 1'b0;
    checkVal("ack_req", W'(WriteReq_o), W'(1));
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_queue: scoreboard empty at ack, WriteReq_o=%0b", WriteReq_o);
      e = '0;
    end else begin
      e = expQ.pop_front();
    end
    checkVal("line_data", WriteData_o, e.data);
    checkVal("line_mask", W'(WriteByteEnable_o), W'(e.mask));
    WriteAck_i = 1'b1;
    @(negedge clk);
    WriteAck_i = 1'b0;
    expCount   = expCount + CW'(1);
    checkVal("ack_count", W'(Count_o), W'(expCount));
    checkVal("ack_done", W'(Done_o), W'(e.last));
  endtask

  task automatic drainAll();
    while (expQ.size() > 0) ackOne();
    checkVal("drained_req", W'(WriteReq_o), W'(0));
  endtask

  task automatic startPulse(input bit withTraffic);
    @(negedge clk);
    Start_i    = 1'b1;
    Valid_i    = withTraffic;
    Data_i     = 32'h55;
    Last_i     = 1'b1;
    WriteAck_i = withTraffic;
    modelClear();
    @(negedge clk);
    Start_i    = 1'b0;
    Valid_i    = 1'b0;
    Last_i     = 1'b0;
    WriteAck_i = 1'b0;
    checkVal("start_req", W'(WriteReq_o), W'(0));
    checkVal("start_count", W'(Count_o), W'(0));
    checkVal("start_ovf", W'(Overflow_o), W'(0));
    checkVal("start_halt", W'(Halt_o), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    Start_i    = 1'b0;
    ShiftBp_i  = 5'd0;
    Relu_i     = 1'b0;
    Valid_i    = 1'b0;
    Data_i     = '0;
    Last_i     = 1'b0;
    WriteAck_i = 1'b0;
    modelClear();
    repeat (3) @(negedge clk);
    checkVal("rst_halt", W'(Halt_o), W'(0));
    checkVal("rst_req", W'(WriteReq_o), W'(0));
    checkVal("rst_data", WriteData_o, W'(0));
    checkVal("rst_mask", W'(WriteByteEnable_o), W'(0));
    checkVal("rst_done", W'(Done_o), W'(0));
    checkVal("rst_count", W'(Count_o), W'(0));
    checkVal("rst_ovf", W'(Overflow_o), W'(0));
    rst = 1'b0;

    // Requantization: round, saturate high, saturate low, round up.
    ShiftBp_i = 5'd4;
    sendItem(32'h0000_0100, 1'b0);
    sendItem(32'h0000_0808, 1'b0);
    sendItem(32'hFFFF_F000, 1'b0);
    sendItem(32'h0000_0018, 1'b1);
    idle();
    checkVal("quant_req", W'(WriteReq_o), W'(1));
    checkVal("quant_bytes", W'(WriteData_o[31:0]), W'(32'h0280_7F10));
    ackOne();

    // Full line of 64 ramp items.
    startPulse(1'b0);
    ShiftBp_i = 5'd0;
    sendRamp(63, 0, 1'b0);
    idle();
    checkVal("full_req_early", W'(WriteReq_o), W'(0));
    sendItem(32'd63, 1'b0);
    idle();
    checkVal("full_req", W'(WriteReq_o), W'(1));
    checkVal("full_mask", W'(WriteByteEnable_o), {W{1'b1}} >> (W - BE));
    checkVal("full_byte63", W'(WriteData_o[511:504]), W'(63));
    ackOne();
    checkVal("full_count1", W'(Count_o), W'(1));

    // Partial line terminated by Last_i, single Done pulse, ack while empty ignored.
    startPulse(1'b0);
    sendRamp(5, 1, 1'b1);
    idle();
    checkVal("part_mask", W'(WriteByteEnable_o), W'(64'h1F));
    ackOne();
    idle();
    checkVal("part_done_once", W'(Done_o), W'(0));
    @(negedge clk);
    WriteAck_i = 1'b1;
    idle();
    checkVal("empty_ack_count", W'(Count_o), W'(expCount));
    checkVal("empty_ack_req", W'(WriteReq_o), W'(0));

    // Backpressure: two full lines fill the FIFO.
    startPulse(1'b0);
    for (int k = 0; k < 128; k++) sendItem(32'(k), 1'b0);
    idle();
    checkVal("bp_halt", W'(Halt_o), W'(1));
    ackOne();
    checkVal("bp_release", W'(Halt_o), W'(0));
    sendItem(32'd128, 1'b0);
    sendItem(32'd129, 1'b1);
    idle();
    drainAll();
    checkVal("bp_ovf", W'(Overflow_o), W'(0));

    // ReLU clamps negatives, positives pass.
    startPulse(1'b0);
    Relu_i = 1'b1;
    sendItem(32'hFFFF_FFFB, 1'b0);
    sendItem(32'd7, 1'b1);
    idle();
    Relu_i = 1'b0;
    checkVal("relu_bytes", W'(WriteData_o[15:0]), W'(16'h0700));
    ackOne();

    // Protocol violation: Valid_i while halted is dropped and flagged.
    sendItem(32'd1, 1'b1);
    sendItem(32'd2, 1'b1);
    idle();
    checkVal("ovf_halt", W'(Halt_o), W'(1));
    @(negedge clk);
    Valid_i = 1'b1;
    Data_i  = 32'd99;
    Last_i  = 1'b1;
    idle();
    checkVal("ovf_flag", W'(Overflow_o), W'(1));
    drainAll();
    sendItem(32'd3, 1'b1);
    idle();
    ackOne();
    checkVal("ovf_sticky", W'(Overflow_o), W'(1));

    // Start_i mid-line with a same-cycle item and ack, then a clean line.
    startPulse(1'b0);
    sendRamp(10, 100, 1'b0);
    startPulse(1'b1);
    sendRamp(64, 20, 1'b0);
    idle();
    ackOne();
    checkVal("start_clean_count", W'(Count_o), W'(1));

    // Asynchronous reset mid-line with a line waiting in the FIFO.
    sendRamp(74, 0, 1'b0);
    @(negedge clk);
    Valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkVal("arst_req", W'(WriteReq_o), W'(0));
    checkVal("arst_count", W'(Count_o), W'(0));
    checkVal("arst_mask", W'(WriteByteEnable_o), W'(0));
    @(negedge clk);
    rst = 1'b0;
    modelClear();
    sendRamp(64, 40, 1'b0);
    idle();
    checkVal("arst_clean_req", W'(WriteReq_o), W'(1));
    ackOne();
    checkVal("arst_clean_count", W'(Count_o), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
